// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave word front end.
//   DEFAULT_WORD_W      : bits per SPI word (reply and receive width)
//   DEFAULT_SYNC_STAGES : flip-flop stages used to bring SPI pins into clk
//   state_t             : front-end frame state (idle, command frame,
//                         data frame, both-selects error)
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int DEFAULT_WORD_W      = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// ---------------------------------------------------------------------------
// spi_pin_sync
// Multi-stage synchroniser for one asynchronous pin, followed by a rise/fall
// detector that compares the last two synchronised samples.
//   clk, rst    : system clock, synchronous active-high reset
//   i_pin       : raw asynchronous pin (idles low, e.g. mode-0 SCL)
//   o_rise      : one-clk strobe on a synchronised 0->1 transition
//   o_fall      : one-clk strobe on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // Shift the pin through the synchroniser chain and keep one extra sample
  // of the synchronised level so edges can be seen one clk later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_prev;
  assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/spi_word_frontend.sv
// ---------------------------------------------------------------------------
// spi_word_frontend
// SPI mode-0 slave physical front end. Synchronises the SPI pins, tracks the
// frame on two active-low selects, deserialises MSB-first words and shifts
// reply words out on SDO.
//   clk, rst         : system clock (>= 8x SCL), synchronous active-high reset
//   spi_scl/sdi/sdo  : SPI clock, master-out data, slave-out data
//   spi_cs_cmd/data  : active-low command / data channel selects
//   rx_valid         : one-clk strobe, rx_data holds a complete word
//   rx_data          : last received word, held until the next rx_valid
//   rx_is_cmd        : word came from the command channel
//   rx_first         : word is the first of its frame (valid with rx_valid)
//   tx_load_req      : one-clk request for the next reply word
//   tx_data          : reply word, sampled on the clk after tx_load_req
//   frame_start/end  : one-clk frame boundary strobes
//   rx_partial       : with frame_end, the frame ended mid-word
//   err_cs_both      : both selects were seen low and not yet both released
// ---------------------------------------------------------------------------
module spi_word_frontend
  import spi_pkg::*;
#(
  parameter int WORD_W      = DEFAULT_WORD_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_scl,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  input  logic              spi_cs_cmd,
  input  logic              spi_cs_data,
  output logic              rx_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_is_cmd,
  output logic              rx_first,
  output logic              tx_load_req,
  input  logic [WORD_W-1:0] tx_data,
  output logic              frame_start,
  output logic              frame_end,
  output logic              rx_partial,
  output logic              err_cs_both
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic                   w_scl_rise;
  logic                   w_scl_fall;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_cmd_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   w_sdi;
  logic                   w_cs_cmd_n;
  logic                   w_cs_data_n;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_frame_start;
  logic                   w_frame_end;
  logic                   w_partial;
  logic                   w_rise_ok;
  logic                   w_fall_ok;
  logic                   w_word_done;

  logic [CNT_W-1:0]       r_bit_cnt;
  logic [WORD_W-2:0]      r_rx_shift;
  logic [WORD_W-1:0]      r_tx_shift;
  logic [WORD_W-1:0]      r_tx_hold;
  logic                   r_reload_pend;
  logic                   r_first_armed;

  logic                   r_rx_valid;
  logic [WORD_W-1:0]      r_rx_data;
  logic                   r_rx_is_cmd;
  logic                   r_rx_first;
  logic                   r_tx_load_req;
  logic                   r_frame_start;
  logic                   r_frame_end;
  logic                   r_rx_partial;

  // SCL needs edge detection, so it gets the dedicated sync/edge block.
  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (spi_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  // Plain synchronisers for data and selects. The selects reset to the
  // released level so the FSM does not see a phantom "both low" right after
  // reset while the chains refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdi_sync  <= '0;
      r_cmd_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      r_cmd_sync  <= {r_cmd_sync[SYNC_STAGES-2:0], spi_cs_cmd};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spi_cs_data};
    end
  end

  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs_cmd_n  = r_cmd_sync[SYNC_STAGES-1];
  assign w_cs_data_n = r_data_sync[SYNC_STAGES-1];

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and event decode. A select change always wins over an SCL
  // edge seen in the same cycle, so edges are only accepted while the frame
  // is staying open.
  always_comb begin
    w_next_state  = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    w_partial     = 1'b0;
    w_rise_ok     = 1'b0;
    w_fall_ok     = 1'b0;
    w_word_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cs_cmd_n && !w_cs_data_n) begin
          w_next_state = ERR;
        end else if (!w_cs_cmd_n) begin
          w_next_state  = CMD;
          w_frame_start = 1'b1;
        end else if (!w_cs_data_n) begin
          w_next_state  = DATA;
          w_frame_start = 1'b1;
        end
      end
      CMD, DATA: begin
        if (!w_cs_cmd_n && !w_cs_data_n) begin
          w_next_state = ERR;
          w_frame_end  = 1'b1;
          w_partial    = (r_bit_cnt != '0);
        end else if ((r_state == CMD) ? w_cs_cmd_n : w_cs_data_n) begin
          w_next_state = IDLE;
          w_frame_end  = 1'b1;
          w_partial    = (r_bit_cnt != '0);
        end else begin
          w_rise_ok   = w_scl_rise;
          w_fall_ok   = w_scl_fall;
          w_word_done = w_scl_rise && (r_bit_cnt == LAST_BIT);
        end
      end
      ERR: begin
        if (w_cs_cmd_n && w_cs_data_n) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Receive path. Only WORD_W-1 bits are kept because the final bit is
  // taken straight from the synchronised SDI on the completing rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_first_armed <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_data     <= '0;
      r_rx_is_cmd   <= 1'b0;
      r_rx_first    <= 1'b0;
    end else begin
      r_rx_valid <= w_word_done;
      r_rx_first <= w_word_done & r_first_armed;
      if (w_frame_start || w_frame_end) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end else if (w_rise_ok) begin
        r_bit_cnt  <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
        r_rx_shift <= {r_rx_shift[WORD_W-3:0], w_sdi};
      end
      if (w_word_done) begin
        r_rx_data   <= {r_rx_shift, w_sdi};
        r_rx_is_cmd <= (r_state == CMD);
      end
      if (w_frame_start) begin
        r_first_armed <= 1'b1;
      end else if (w_word_done) begin
        r_first_armed <= 1'b0;
      end
    end
  end

  // Transmit path. The reply requested at frame start goes straight into the
  // shifter; later replies wait in tx_hold and replace the shifter on the
  // SCL fall that follows the word boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_shift    <= '0;
      r_tx_hold     <= '0;
      r_reload_pend <= 1'b0;
    end else if (w_frame_start || w_frame_end) begin
      r_reload_pend <= 1'b0;
    end else begin
      if (w_fall_ok) begin
        if (r_reload_pend) begin
          r_tx_shift    <= r_tx_hold;
          r_reload_pend <= 1'b0;
        end else begin
          r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
        end
      end
      if (r_tx_load_req) begin
        if (r_frame_start) begin
          r_tx_shift <= tx_data;
        end else begin
          r_tx_hold     <= tx_data;
          r_reload_pend <= 1'b1;
        end
      end
    end
  end

  // Registered frame strobes and reply requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_load_req <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_rx_partial  <= 1'b0;
    end else begin
      r_tx_load_req <= w_frame_start | w_word_done;
      r_frame_start <= w_frame_start;
      r_frame_end   <= w_frame_end;
      r_rx_partial  <= w_frame_end & w_partial;
    end
  end

  assign spi_sdo     = ((r_state == CMD) || (r_state == DATA)) ? r_tx_shift[WORD_W-1] : 1'b0;
  assign err_cs_both = (r_state == ERR);
  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign rx_is_cmd   = r_rx_is_cmd;
  assign rx_first    = r_rx_first;
  assign tx_load_req = r_tx_load_req;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign rx_partial  = r_rx_partial;

endmodule

// File: tb/tb_spi_word_frontend.sv
// ---------------------------------------------------------------------------
// tb_spi_word_frontend
// Directed bench for spi_word_frontend. A bench-side SPI master drives the
// pins; a word-level model (expected word / frame-end queues and event
// counts) is filled by the master and checked against the DUT by one
// compare process, with literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_spi_word_frontend;

  localparam int WORD_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  typedef struct packed {
    logic        isCmd;
    logic        first;
    logic [15:0] data;
  } rxWord_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        spiScl    = 1'b0;
  logic        spiSdi    = 1'b0;
  logic        spiCsCmd  = 1'b1;
  logic        spiCsData = 1'b1;
  logic [15:0] txData    = '0;

  logic        spi_sdo;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_is_cmd;
  logic        rx_first;
  logic        tx_load_req;
  logic        frame_start;
  logic        frame_end;
  logic        rx_partial;
  logic        err_cs_both;

  int          testsRun    = 0;
  int          testsFailed = 0;

  rxWord_t     expRx[$];
  logic        expEnd[$];
  int          expStarts   = 0;
  int          expLoads    = 0;
  int          seenStarts  = 0;
  int          seenLoads   = 0;
  int          idleCnt     = 0;
  int          bitsInFrame = 0;
  logic        curIsCmd    = 1'b0;
  logic        curFirst    = 1'b0;
  logic [15:0] rxAcc       = '0;
  rxWord_t     expWord;
  rxWord_t     pushWord;
  logic        expPartial;
  logic [15:0] sdoWord;

  spi_word_frontend #(
    .WORD_W      (WORD_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_scl     (spiScl),
    .spi_sdi     (spiSdi),
    .spi_sdo     (spi_sdo),
    .spi_cs_cmd  (spiCsCmd),
    .spi_cs_data (spiCsData),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_is_cmd   (rx_is_cmd),
    .rx_first    (rx_first),
    .tx_load_req (tx_load_req),
    .tx_data     (txData),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .rx_partial  (rx_partial),
    .err_cs_both (err_cs_both)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every output packed together; used where everything must be zero.
  function automatic logic [31:0] allOutputs();
    return 32'({rx_valid, rx_data, rx_is_cmd, rx_first, tx_load_req,
                frame_start, frame_end, rx_partial, err_cs_both, spi_sdo});
  endfunction

  // Open a frame on one channel; the model expects a start and one reply load.
  task automatic beginFrame(input logic isCmd);
    if (isCmd) spiCsCmd = 1'b0;
    else       spiCsData = 1'b0;
    curIsCmd    = isCmd;
    curFirst    = 1'b1;
    bitsInFrame = 0;
    rxAcc       = '0;
    expStarts++;
    expLoads++;
    waitClk(10);
  endtask

  // Clock nBits of data MSB-first, collecting SDO just before each rise.
  // Each 16th bit completes a word the DUT must report.
  task automatic applyStimulus(input logic [15:0] data, input int nBits, output logic [15:0] sdo);
    sdo = '0;
    for (int i = nBits - 1; i >= 0; i--) begin
      spiSdi = data[i];
      waitClk(HALF);
      sdo    = {sdo[14:0], spi_sdo};
      spiScl = 1'b1;
      rxAcc  = {rxAcc[14:0], data[i]};
      bitsInFrame++;
      if ((bitsInFrame % 16) == 0) begin
        pushWord = '{isCmd: curIsCmd, first: curFirst, data: rxAcc};
        expRx.push_back(pushWord);
        curFirst = 1'b0;
        expLoads++;
      end
      waitClk(HALF);
      spiScl = 1'b0;
    end
  endtask

  task automatic endFrame();
    waitClk(HALF);
    spiCsCmd  = 1'b1;
    spiCsData = 1'b1;
    expEnd.push_back((bitsInFrame % 16) != 0);
    waitClk(10);
  endtask

  // Compare process: every word strobe and frame end against the model,
  // no strobes while in the error state, SDO quiet once both selects idle.
  always @(negedge clk) begin
    if (rst) begin
      idleCnt = 0;
    end else begin
      if (spiCsCmd && spiCsData) idleCnt++;
      else                       idleCnt = 0;
      if (rx_valid) begin
        if (expRx.size() == 0) begin
          checkOutput("unexpectedRxValid", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          expWord = expRx.pop_front();
          checkOutput("rxWord", 32'({rx_is_cmd, rx_first, rx_data}), 32'(expWord));
        end
      end
      if (frame_end) begin
        if (expEnd.size() == 0) begin
          checkOutput("unexpectedFrameEnd", 32'(frame_end), 32'd0);
        end else begin
          expPartial = expEnd.pop_front();
          checkOutput("rxPartial", 32'(rx_partial), 32'(expPartial));
        end
      end else if (rx_partial) begin
        checkOutput("partialWithoutEnd", 32'(rx_partial), 32'd0);
      end
      if (frame_start) seenStarts++;
      if (tx_load_req) seenLoads++;
      if (err_cs_both) begin
        checkOutput("noStrobeInErr", 32'({rx_valid, frame_start, tx_load_req}), 32'd0);
      end
      if (idleCnt > SYNC_STAGES + 2) begin
        checkOutput("sdoIdle", 32'(spi_sdo), 32'd0);
      end
    end
  end

  initial begin
    // Reset state.
    waitClk(5);
    checkOutput("resetOutputs", allOutputs(), 32'd0);
    rst = 1'b0;
    waitClk(5);

    // Single command word.
    txData = 16'h0000;
    beginFrame(1'b1);
    applyStimulus(16'hA5C3, 16, sdoWord);
    endFrame();
    checkOutput("rxDataHeldA5C3", 32'(rx_data), 32'h0000_A5C3);
    checkOutput("rxIsCmdHeld", 32'(rx_is_cmd), 32'd1);

    // Two data words with two reply words.
    txData = 16'h1234;
    beginFrame(1'b0);
    txData = 16'hBEEF;
    applyStimulus(16'h0001, 16, sdoWord);
    checkOutput("sdoWord0", 32'(sdoWord), 32'h0000_1234);
    applyStimulus(16'h0002, 16, sdoWord);
    checkOutput("sdoWord1", 32'(sdoWord), 32'h0000_BEEF);
    endFrame();
    checkOutput("rxDataHeld0002", 32'(rx_data), 32'h0000_0002);

    // Frame aborted after 9 bits, then a clean frame.
    beginFrame(1'b1);
    applyStimulus(16'h0155, 9, sdoWord);
    endFrame();
    checkOutput("rxDataAfterPartial", 32'(rx_data), 32'h0000_0002);
    beginFrame(1'b1);
    applyStimulus(16'h00FF, 16, sdoWord);
    endFrame();
    checkOutput("rxData00FF", 32'(rx_data), 32'h0000_00FF);

    // Both selects low together.
    spiCsCmd  = 1'b0;
    spiCsData = 1'b0;
    waitClk(10);
    checkOutput("errEnter", 32'(err_cs_both), 32'd1);
    for (int p = 0; p < 40; p++) begin
      spiSdi = p[0];
      spiScl = 1'b1;
      waitClk(4);
      spiScl = 1'b0;
      waitClk(4);
      if ((p % 10) == 0) checkOutput("sdoInErr", 32'(spi_sdo), 32'd0);
    end
    spiCsCmd = 1'b1;
    waitClk(10);
    checkOutput("errHoldOneHigh", 32'(err_cs_both), 32'd1);
    spiCsData = 1'b1;
    waitClk(10);
    checkOutput("errCleared", 32'(err_cs_both), 32'd0);
    beginFrame(1'b0);
    applyStimulus(16'h1357, 16, sdoWord);
    endFrame();
    checkOutput("rxData1357", 32'(rx_data), 32'h0000_1357);

    // Reset in the middle of a data frame.
    beginFrame(1'b0);
    applyStimulus(16'h00C3, 8, sdoWord);
    rst = 1'b1;
    waitClk(1);
    checkOutput("midFrameReset", allOutputs(), 32'd0);
    spiCsData = 1'b1;
    spiScl    = 1'b0;
    waitClk(4);
    rst = 1'b0;
    waitClk(6);
    beginFrame(1'b0);
    applyStimulus(16'h5A5A, 16, sdoWord);
    endFrame();
    checkOutput("rxData5A5A", 32'(rx_data), 32'h0000_5A5A);

    // SCL activity with no select.
    for (int p = 0; p < 20; p++) begin
      spiSdi = ~p[0];
      spiScl = 1'b1;
      waitClk(4);
      spiScl = 1'b0;
      waitClk(4);
    end
    waitClk(10);

    // Model bookkeeping must be fully consumed.
    checkOutput("frameStarts", 32'(seenStarts), 32'(expStarts));
    checkOutput("txLoadReqs", 32'(seenLoads), 32'(expLoads));
    checkOutput("frameStartsLiteral", 32'(seenStarts), 32'd7);
    checkOutput("pendingRxWords", 32'(expRx.size()), 32'd0);
    checkOutput("pendingFrameEnds", 32'(expEnd.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/spi_word_frontend.md
Name: spi_word_frontend

Overview:
- SPI-slave physical front end directly upstream of the SPI command/register interface.
- Synchronises the raw SPI pins into the system clock domain and detects SCL edges.
- Deserialises 16-bit MSB-first words and serialises reply words onto SDO.
- Hands the interface layer clean single-cycle word strobes tagged command/data, plus frame start/end events.

Parameters:
- WORD_W, 16: bits per SPI word; also the rx_data and tx_data width.
- SYNC_STAGES, 2: flip-flop stages on spi_scl, spi_sdi and both chip selects (minimum 2).

Ports:
- clk  in  1  system clock; f_clk >= 8 x f_scl.
- rst  in  1  synchronous, active-high reset.
- spi_scl  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_sdi  in  1  master-out data.
- spi_sdo  out  1  slave-out data; driven 0 when no frame is active.
- spi_cs_cmd  in  1  active-low command-channel select.
- spi_cs_data  in  1  active-low data-channel select.
- rx_valid  out  1  one-clk strobe: rx_data holds a complete word.
- rx_data  out  WORD_W  last received word; held until the next rx_valid.
- rx_is_cmd  out  1  qualifies rx_valid: 1 = command channel, 0 = data channel.
- rx_first  out  1  qualifies rx_valid: first word of the frame.
- tx_load_req  out  1  one-clk strobe requesting the next reply word.
- tx_data  in  WORD_W  reply word; must be stable on the clk after tx_load_req.
- frame_start  out  1  one-clk strobe when a valid select asserts.
- frame_end  out  1  one-clk strobe when the active select deasserts.
- rx_partial  out  1  one-clk strobe with frame_end if bit count != 0.
- err_cs_both  out  1  level: both selects low, or error not yet cleared.

Behaviour:
- Reset: all outputs 0, rx_data 0, shift registers 0, bit_cnt 0, state IDLE.
- Every input passes through SYNC_STAGES flip-flops.
- SCL rise/fall are detected from the last two synchronised samples.
- Pin-to-decision latency is SYNC_STAGES+1 clk.
- FSM states IDLE, CMD, DATA, ERR; transitions are evaluated on synchronised selects:
  - IDLE -> CMD: cs_cmd low and cs_data high.
  - IDLE -> DATA: cs_data low and cs_cmd high.
  - IDLE -> ERR: both low in the same cycle.
  - On entry to CMD or DATA: frame_start=1, tx_load_req=1, bit_cnt=0, rx_first armed.
  - CMD/DATA -> IDLE: the active select goes high; frame_end=1.
  - CMD/DATA -> ERR: the other select also goes low; frame_end=1, rx_partial per bit_cnt.
  - ERR -> IDLE: only once both selects are high.
  - In ERR: err_cs_both=1, SDO=0, no strobes.
- Receive:
  - On each SCL rise in CMD/DATA: rx_shift <= {rx_shift[WORD_W-2:0], sdi}.
  - bit_cnt increments and wraps WORD_W-1 -> 0.
  - On the wrapping rise, in the next clk: rx_data <= completed word, rx_valid=1.
  - rx_is_cmd reflects the state; rx_first=1 only for the first word after frame_start.
  - The same clk as rx_valid raises tx_load_req.
- Transmit:
  - spi_sdo = tx_shift[WORD_W-1] in CMD/DATA, else 0.
  - Frame start: tx_shift <= tx_data on the clk after tx_load_req.
  - Mid-frame: tx_hold <= tx_data on the clk after tx_load_req and reload_pend is set.
  - On an SCL fall: if reload_pend, tx_shift <= tx_hold and reload_pend clears; otherwise shift left by 1, filling 0.
- SCL edges outside CMD/DATA are ignored.
- CS deassert mid-word:
  - Partial rx bits are discarded; rx_valid is not raised.
  - rx_partial=1 with frame_end.
  - bit_cnt and reload_pend clear.
- Simultaneous events:
  - SCL edge in the same synchronised cycle as CS deassert: deassert wins and the edge is dropped.
  - rst overrides everything, including mid-frame; no frame_end is emitted.

Decomposition:
- Shared package spi_pkg:
  - WORD_W default.
  - FSM state encoding constants: IDLE, CMD, DATA, ERR.
- One sub-module, spi_pin_sync: parameterised SYNC_STAGES synchroniser plus rise/fall edge detector, instantiated for scl.
- Plain synchronisers for sdi and both selects.

Test Plan:
- cs_cmd low, master sends 0xA5C3, cs high -> frame_start; then exactly one rx_valid with rx_data=0xA5C3, rx_is_cmd=1, rx_first=1; then frame_end, rx_partial=0.
- cs_data low, tx_data=0x1234 at the first tx_load_req and 0xBEEF at the second; master clocks 32 bits sending 0x0001,0x0002 -> SDO bits read 0x1234 then 0xBEEF; rx_valid twice with rx_is_cmd=0, rx_first 1 then 0.
- cs_cmd low, 9 bits clocked, cs high -> no rx_valid; frame_end and rx_partial together; next frame receives 0x00FF correctly (bit_cnt was cleared).
- Both selects driven low together -> err_cs_both=1; no strobes while 40 SCL pulses are sent; cs_cmd alone returns high -> still ERR; both high -> IDLE; a subsequent frame works.
- rst asserted after 8 bits of a data frame -> next clk all outputs 0; deassert rst, new frame 0x5A5A -> received intact.
- SCL toggling with both selects high -> no rx_valid, spi_sdo=0 throughout.
